// File: rtl/pump_ctrl_pkg.sv
// pump_ctrl_pkg: shared types and constants for the pump3/mux3 pneumatic
// sequencer.
//   state_t      - sequencer FSM states
//   AIR_CLOSED / AIR_OPEN
//                - air-line levels (pressurised air closes a valve)
//   SEL_*        - mux inlet encodings carried on cmd_sel
//   PHASE_PAT    - {pump1,pump2,pump3} pattern for peristaltic phases P0..P5
//   mux_air()    - {sc,sb,sa} levels with only the selected inlet open
package pump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BREAK  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PUMP   = 3'd3,
    ST_PARK   = 3'd4
  } state_t;

  localparam logic AIR_CLOSED = 1'b1;
  localparam logic AIR_OPEN   = 1'b0;

  localparam logic [1:0] SEL_A       = 2'd0;
  localparam logic [1:0] SEL_B       = 2'd1;
  localparam logic [1:0] SEL_C       = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  localparam int NUM_PHASES = 6;

  localparam logic [2:0] PHASE_PAT [0:NUM_PHASES-1] = '{
    3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
  };

  // Bit 0 = sa, bit 1 = sb, bit 2 = sc. An illegal select opens nothing.
  function automatic logic [2:0] mux_air(input logic [1:0] sel);
    logic [2:0] m;
    m = {3{AIR_CLOSED}};
    case (sel)
      SEL_A:   m[0] = AIR_OPEN;
      SEL_B:   m[1] = AIR_OPEN;
      SEL_C:   m[2] = AIR_OPEN;
      default: m = {3{AIR_CLOSED}};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/air_dwell_timer.sv
// air_dwell_timer: load / count-down timer used for every dwell interval
// (break, settle, park) and every peristaltic phase.
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - load load_val this edge (takes priority over counting)
//   load_val    - interval length in cycles (>= 1)
//   expired     - high during the last cycle of the loaded interval
// A value of N loaded on edge E makes expired high in the cycle ending at
// edge E+N, so the owner moves on exactly N cycles after loading.
module air_dwell_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/pump3_mux_ctrl.sv
// pump3_mux_ctrl: sequences the air lines of one 3-inlet mux (sa/sb/sc) and
// one 3-valve peristaltic pump (pump1..3).
//   clk, rst_n           - clock, synchronous active-low reset
//   cmd_valid/cmd_ready  - command handshake
//   cmd_sel/rev/strokes  - inlet (3 = illegal), direction, stroke count
//   abort                - abandon the active command (via PARK)
//   sa, sb, sc           - mux valve air (1 = closed)
//   pump1..pump3         - pump valve air (1 = closed)
//   busy                 - not idle
//   done, done_err, done_aborted - one-cycle completion pulse and status
//   strokes_done         - strokes completed for current/last command
//   dbg_state            - current FSM state
//
// Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
// cmd_ready is high only while idle and the command fields are sampled on
// that edge only. cmd_valid may be held across the done cycle to chain a
// command; the chained one still runs BREAK first.
//
// Every output is a register loaded from the next-state view, so the air
// lines change on the very edge the FSM changes state.
module pump3_mux_ctrl
  import pump_ctrl_pkg::*;
#(
  parameter int PHASE_CYCLES = 1000,
  parameter int DEAD_CYCLES  = 500,
  parameter int STROKE_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_sel,
  input  logic                cmd_rev,
  input  logic [STROKE_W-1:0] cmd_strokes,
  input  logic                abort,
  output logic                sa,
  output logic                sb,
  output logic                sc,
  output logic                pump1,
  output logic                pump2,
  output logic                pump3,
  output logic                busy,
  output logic                done,
  output logic                done_err,
  output logic                done_aborted,
  output logic [STROKE_W-1:0] strokes_done,
  output state_t              dbg_state
);

  localparam int MAX_DWELL = (PHASE_CYCLES > DEAD_CYCLES) ? PHASE_CYCLES : DEAD_CYCLES;
  localparam int TW        = $clog2(MAX_DWELL + 1);
  localparam logic [TW-1:0] DEAD_LD  = TW'(DEAD_CYCLES);
  localparam logic [TW-1:0] PHASE_LD = TW'(PHASE_CYCLES);

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic                rev_q, rev_d;
  logic [STROKE_W-1:0] strokes_q, strokes_d;
  logic [STROKE_W-1:0] cnt_q, cnt_d;
  logic [STROKE_W-1:0] cnt_inc;
  logic [2:0]          pos_q, pos_d;
  logic                aborted_q, aborted_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_expired;

  logic [2:0]          mux_d;
  logic [2:0]          pump_d;
  logic [2:0]          pat_idx;
  logic                done_d, err_d, abt_d;
  logic                accept;

  assign accept  = cmd_valid && cmd_ready;
  assign cnt_inc = cnt_q + STROKE_W'(1);

  air_dwell_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rev_d     = rev_q;
    strokes_d = strokes_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    aborted_d = aborted_q;
    tmr_load  = 1'b0;
    tmr_val   = DEAD_LD;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abt_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort is deliberately ignored here, even alongside an accept
        if (accept) begin
          if (cmd_sel == SEL_ILLEGAL) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d   = ST_BREAK;
            sel_d     = cmd_sel;
            rev_d     = cmd_rev;
            strokes_d = cmd_strokes;
            cnt_d     = '0;
            aborted_d = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = DEAD_LD;
          end
        end
      end

      ST_BREAK, ST_SETTLE, ST_PUMP: begin
        if (abort) begin
          // Abort wins over a coincident expiry: the phase (and any stroke
          // it would have finished) is not credited.
          state_d   = ST_PARK;
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = DEAD_LD;
        end else if (tmr_expired) begin
          tmr_load = 1'b1;
          if (state_q == ST_BREAK) begin
            state_d = ST_SETTLE;
            tmr_val = DEAD_LD;
          end else if (state_q == ST_SETTLE) begin
            if (strokes_q == '0) begin
              state_d = ST_PARK;
              tmr_val = DEAD_LD;
            end else begin
              state_d = ST_PUMP;
              pos_d   = 3'd0;
              tmr_val = PHASE_LD;
            end
          end else if (pos_q == 3'(NUM_PHASES - 1)) begin
            // Stroke boundary; cnt_q < strokes_q here, so no wrap.
            cnt_d = cnt_inc;
            if (cnt_inc == strokes_q) begin
              state_d = ST_PARK;
              tmr_val = DEAD_LD;
            end else begin
              pos_d   = 3'd0;
              tmr_val = PHASE_LD;
            end
          end else begin
            pos_d   = pos_q + 3'd1;
            tmr_val = PHASE_LD;
          end
        end
      end

      ST_PARK: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          abt_d   = aborted_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Air levels for the state being entered
  always_comb begin
    mux_d   = {3{AIR_CLOSED}};
    pump_d  = {3{AIR_CLOSED}};
    pat_idx = rev_d ? (3'(NUM_PHASES - 1) - pos_d) : pos_d;
    if (state_d == ST_SETTLE || state_d == ST_PUMP) begin
      mux_d = mux_air(sel_d);
    end
    if (state_d == ST_PUMP) begin
      pump_d = PHASE_PAT[pat_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= SEL_A;
      rev_q        <= 1'b0;
      strokes_q    <= '0;
      cnt_q        <= '0;
      pos_q        <= 3'd0;
      aborted_q    <= 1'b0;
      sa           <= AIR_CLOSED;
      sb           <= AIR_CLOSED;
      sc           <= AIR_CLOSED;
      pump1        <= AIR_CLOSED;
      pump2        <= AIR_CLOSED;
      pump3        <= AIR_CLOSED;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_err     <= 1'b0;
      done_aborted <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rev_q        <= rev_d;
      strokes_q    <= strokes_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      aborted_q    <= aborted_d;
      sa           <= mux_d[0];
      sb           <= mux_d[1];
      sc           <= mux_d[2];
      pump1        <= pump_d[2];
      pump2        <= pump_d[1];
      pump3        <= pump_d[0];
      cmd_ready    <= (state_d == ST_IDLE);
      busy         <= (state_d != ST_IDLE);
      done         <= done_d;
      done_err     <= err_d;
      done_aborted <= abt_d;
    end
  end

  assign strokes_done = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pump3_mux_ctrl.sv
module tb_pump3_mux_ctrl;
  import pump_ctrl_pkg::*;

  localparam int P  = 2;
  localparam int D  = 3;
  localparam int SW = 16;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_sel;
  logic          cmd_rev;
  logic [SW-1:0] cmd_strokes;
  logic          abort;
  logic          sa, sb, sc;
  logic          pump1, pump2, pump3;
  logic          busy, done, done_err, done_aborted;
  logic [SW-1:0] strokes_done;
  state_t        dbg_state;

  pump3_mux_ctrl #(
    .PHASE_CYCLES (P),
    .DEAD_CYCLES  (D),
    .STROKE_W     (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sel      (cmd_sel),
    .cmd_rev      (cmd_rev),
    .cmd_strokes  (cmd_strokes),
    .abort        (abort),
    .sa           (sa),
    .sb           (sb),
    .sc           (sc),
    .pump1        (pump1),
    .pump2        (pump2),
    .pump3        (pump3),
    .busy         (busy),
    .done         (done),
    .done_err     (done_err),
    .done_aborted (done_aborted),
    .strokes_done (strokes_done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- observation record ----------------
  typedef struct packed {
    logic [2:0]    mux;   // {sc,sb,sa}
    logic [2:0]    pump;  // {pump1,pump2,pump3}
    logic          busy;
    logic          done;
    logic          err;
    logic          abt;
    logic          ready;
    logic [SW-1:0] sd;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  logic [OBS_W-1:0] exp_q[$];
  int               n_cmp  = 0;
  int               n_fail = 0;
  logic [SW-1:0]    last_sd = '0;

  // Peristaltic patterns written out from the sequence description
  logic [2:0] ref_pat [0:5];
  initial begin
    ref_pat[0] = 3'b101; ref_pat[1] = 3'b100; ref_pat[2] = 3'b110;
    ref_pat[3] = 3'b010; ref_pat[4] = 3'b011; ref_pat[5] = 3'b001;
  end

  function automatic obs_t get_obs();
    obs_t o;
    o.mux   = {sc, sb, sa};
    o.pump  = {pump1, pump2, pump3};
    o.busy  = busy;
    o.done  = done;
    o.err   = done_err;
    o.abt   = done_aborted;
    o.ready = cmd_ready;
    o.sd    = strokes_done;
    return o;
  endfunction

  function automatic obs_t mk_obs(input logic [2:0] mux, input logic [2:0] pump,
                                  input logic bsy, input logic dn, input logic er,
                                  input logic ab, input logic [SW-1:0] sd);
    obs_t o;
    o.mux = mux; o.pump = pump; o.busy = bsy; o.done = dn;
    o.err = er;  o.abt = ab;    o.ready = ~bsy; o.sd = sd;
    return o;
  endfunction

  task automatic check_obs(input string name, input int k, input obs_t g, input obs_t e);
    n_cmp++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s k=%0d got mux=%b pump=%b busy=%b done=%b err=%b abt=%b rdy=%b sd=%0d | expected mux=%b pump=%b busy=%b done=%b err=%b abt=%b rdy=%b sd=%0d",
               name, k, g.mux, g.pump, g.busy, g.done, g.err, g.abt, g.ready, g.sd,
               e.mux, e.pump, e.busy, e.done, e.err, e.abt, e.ready, e.sd);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Expands one command into its per-cycle output trace, cycle 1 being the
  // cycle right after the accept edge and the final entry the done cycle.
  task automatic build_exp(input logic [1:0] sel, input logic rev, input int n, input int a);
    int   active_end, stop, j, stroke, ph;
    logic ab;
    logic [2:0] open_mux;
    logic [SW-1:0] sd_final;
    exp_q.delete();
    if (sel == 2'd3) begin
      exp_q.push_back(mk_obs(3'b111, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, last_sd));
      return;
    end
    open_mux   = ~(3'b001 << sel);
    active_end = 2 * D + 6 * n * P;
    ab         = (a >= 1) && (a <= active_end);
    stop       = ab ? a : active_end;
    sd_final   = SW'(n);
    for (int k = 1; k <= stop; k++) begin
      if (k <= D) begin
        exp_q.push_back(mk_obs(3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, '0));
        sd_final = '0;
      end else if (k <= 2 * D) begin
        exp_q.push_back(mk_obs(open_mux, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, '0));
        sd_final = '0;
      end else begin
        j      = k - 2 * D - 1;
        stroke = j / (6 * P);
        ph     = (j % (6 * P)) / P;
        exp_q.push_back(mk_obs(open_mux, rev ? ref_pat[5 - ph] : ref_pat[ph],
                               1'b1, 1'b0, 1'b0, 1'b0, SW'(stroke)));
        sd_final = SW'(stroke);
      end
    end
    if (!ab) sd_final = SW'(n);
    for (int k = 0; k < D; k++)
      exp_q.push_back(mk_obs(3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, sd_final));
    exp_q.push_back(mk_obs(3'b111, 3'b111, 1'b0, 1'b1, 1'b0, ab, sd_final));
  endtask

  // ---------------- driver tasks ----------------
  // Starts at a negedge with the DUT idle. Returns at the negedge of the
  // done cycle so that an immediately following call chains back-to-back.
  task automatic run_cmd(input string name, input logic [1:0] sel, input logic rev,
                         input int n, input int a, input logic abort_acc, input int rst_at,
                         output int done_k, output int sd_end, output int err_end,
                         output int abt_end);
    int   len;
    obs_t e, g;
    build_exp(sel, rev, n, a);
    len         = exp_q.size();
    cmd_valid   = 1'b1;
    cmd_sel     = sel;
    cmd_rev     = rev;
    cmd_strokes = SW'(n);
    abort       = abort_acc;
    done_k = 0; sd_end = 0; err_end = 0; abt_end = 0;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      abort     = (k == a);
      g = get_obs();
      e = obs_t'(exp_q.pop_front());
      check_obs(name, k, g, e);
      if (g.done && done_k == 0) done_k = k;
      sd_end = int'(g.sd); err_end = int'(g.err); abt_end = int'(g.abt);
      last_sd = e.sd;
      if (rst_at != 0 && k == rst_at) begin
        abort = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_sd = '0;
        check_obs({name, "_reset"}, k + 1, get_obs(),
                  mk_obs(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        exp_q.delete();
        return;
      end
    end
  endtask

  // Idle cycles with random abort, which must be ignored while idle
  task automatic idle_cycles(input int m);
    for (int i = 0; i < m; i++) begin
      cmd_valid = 1'b0;
      abort     = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check_obs("idle", i, get_obs(),
                mk_obs(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, last_sd));
    end
    abort = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] sel;
    logic       rev;
    int         n;
    int         a;
    int         exp_done_k;
    int         exp_sd;
    int         exp_err;
    int         exp_abt;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    int dk, sdv, erv, abv, sel_r, n_r, a_r, acc_r;
    // sel rev n  abort_at  done_k sd err abt
    vecs[0] = '{2'd1, 1'b0, 2, 0,  34, 2, 0, 0};  // forward, 2 strokes
    vecs[1] = '{2'd1, 1'b1, 2, 0,  34, 2, 0, 0};  // reverse, chained
    vecs[2] = '{2'd2, 1'b0, 0, 0,  10, 0, 0, 0};  // zero strokes
    vecs[3] = '{2'd3, 1'b0, 1, 0,   1, 0, 1, 0};  // illegal select
    vecs[4] = '{2'd0, 1'b0, 2, 14, 18, 0, 0, 1};  // abort 2nd cycle of P3
    vecs[5] = '{2'd0, 1'b0, 3, 2,   6, 0, 0, 1};  // abort in BREAK
    vecs[6] = '{2'd2, 1'b1, 1, 20, 22, 1, 0, 0};  // abort in PARK ignored
    vecs[7] = '{2'd1, 1'b0, 3, 22, 26, 1, 0, 1};  // abort in stroke 2

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_rev = 1'b0;
    cmd_strokes = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_obs("reset", 0, get_obs(),
              mk_obs(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    rst_n = 1'b1;
    idle_cycles(2);

    // Table entries run back-to-back: each accept lands in the done cycle
    for (int i = 0; i < 8; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].sel, vecs[i].rev, vecs[i].n,
              vecs[i].a, 1'b0, 0, dk, sdv, erv, abv);
      check_int($sformatf("vec%0d_done_k", i), dk, vecs[i].exp_done_k);
      check_int($sformatf("vec%0d_sd", i), sdv, vecs[i].exp_sd);
      check_int($sformatf("vec%0d_err", i), erv, vecs[i].exp_err);
      check_int($sformatf("vec%0d_abt", i), abv, vecs[i].exp_abt);
    end
    idle_cycles(2);

    // Abort coinciding with an accept must not cancel the command
    run_cmd("abort_at_accept", 2'd0, 1'b1, 1, 0, 1'b1, 0, dk, sdv, erv, abv);
    check_int("abort_at_accept_done_k", dk, 22);
    check_int("abort_at_accept_abt", abv, 0);
    idle_cycles(1);

    // Reset in the middle of PUMP: all closed, idle, no done pulse
    run_cmd("reset_mid_pump", 2'd0, 1'b0, 2, 0, 1'b0, 16, dk, sdv, erv, abv);
    check_int("reset_mid_pump_no_done", dk, 0);
    idle_cycles(3);

    // Randomised commands against the model
    for (int i = 0; i < 25; i++) begin
      sel_r = $urandom_range(0, 3);
      n_r   = $urandom_range(0, 3);
      a_r   = 0;
      if (sel_r != 3 && $urandom_range(0, 2) == 0)
        a_r = $urandom_range(1, 3 * D + 6 * n_r * P);
      acc_r = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_cmd($sformatf("rand%0d", i), 2'(sel_r), 1'($urandom_range(0, 1)), n_r,
              a_r, 1'(acc_r), 0, dk, sdv, erv, abv);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
